// File: rtl/tape_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tape_pkg: pulse classes, decoder states and default tape thresholds  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tape_pkg;

  typedef enum logic [2:0] {
    CLS_NOISE = 3'd0,
    CLS_SYNC  = 3'd1,
    CLS_ZERO  = 3'd2,
    CLS_ONE   = 3'd3,
    CLS_PILOT = 3'd4,
    CLS_LONG  = 3'd5
  } pulse_class_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PILOT  = 3'd1,
    ST_SYNC2  = 3'd2,
    ST_BIT_H1 = 3'd3,
    ST_BIT_H2 = 3'd4
  } state_e;

  localparam int unsigned DEF_CNT_W     = 14;
  localparam int unsigned DEF_T_NOISE   = 1600;
  localparam int unsigned DEF_T_SYNC    = 3180;
  localparam int unsigned DEF_T_ZERO    = 5000;
  localparam int unsigned DEF_T_ONE     = 7800;
  localparam int unsigned DEF_T_PILOT   = 10000;
  localparam int unsigned DEF_PILOT_MIN = 256;

  // Thresholds are lower bounds of the next class up.
  function automatic pulse_class_e classify_width(
    input int unsigned width,
    input int unsigned t_noise,
    input int unsigned t_sync,
    input int unsigned t_zero,
    input int unsigned t_one,
    input int unsigned t_pilot
  );
    if (width < t_noise)      return CLS_NOISE;
    else if (width < t_sync)  return CLS_SYNC;
    else if (width < t_zero)  return CLS_ZERO;
    else if (width < t_one)   return CLS_ONE;
    else if (width < t_pilot) return CLS_PILOT;
    else                      return CLS_LONG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tape_pulse_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tape_pulse_meter: synchronises tape_in, measures and classifies      |
// | half-period widths, flags counter saturation.  Rev 1.0               |
// +----------------------------------------------------------------------+
module tape_pulse_meter
  import tape_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned T_NOISE = DEF_T_NOISE,
  parameter int unsigned T_SYNC  = DEF_T_SYNC,
  parameter int unsigned T_ZERO  = DEF_T_ZERO,
  parameter int unsigned T_ONE   = DEF_T_ONE,
  parameter int unsigned T_PILOT = DEF_T_PILOT
) (
  input  logic         clk14,
  input  logic         rst_n,
  input  logic         tape_in,
  output logic         pulse_stb,
  output pulse_class_e pulse_class,
  output logic         timeout_stb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             edge_q, edge_d;
  logic             pulse_stb_q, pulse_stb_d;
  logic             timeout_q, timeout_d;
  pulse_class_e     class_q, class_d;
  logic             edge_det;

  always_comb begin
    sync_d      = {sync_q[1:0], tape_in};
    edge_det    = sync_q[1] ^ sync_q[2];
    edge_d      = edge_det;
    width_d     = edge_det ? cnt_q : width_q;
    // An edge coinciding with saturation suppresses the timeout.
    timeout_d   = !edge_det && (cnt_q == CNT_PRE);
    if (edge_det)              cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
    pulse_stb_d = edge_q;
    class_d     = class_q;
    if (edge_q) begin
      if (width_q >= CNT_PRE) class_d = CLS_LONG;
      else class_d = classify_width(int'(width_q), T_NOISE, T_SYNC, T_ZERO, T_ONE, T_PILOT);
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      width_q     <= '0;
      edge_q      <= 1'b0;
      pulse_stb_q <= 1'b0;
      timeout_q   <= 1'b0;
      class_q     <= CLS_NOISE;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      edge_q      <= edge_d;
      pulse_stb_q <= pulse_stb_d;
      timeout_q   <= timeout_d;
      class_q     <= class_d;
    end
  end

  assign pulse_stb   = pulse_stb_q;
  assign pulse_class = class_q;
  assign timeout_stb = timeout_q;

endmodule
`default_nettype wire

// File: rtl/tape_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tape_decoder: ZX Spectrum tape block receiver (pilot, sync, bytes,   |
// | XOR checksum).  Rev 1.0                                              |
// +----------------------------------------------------------------------+
module tape_decoder
  import tape_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned T_NOISE   = DEF_T_NOISE,
  parameter int unsigned T_SYNC    = DEF_T_SYNC,
  parameter int unsigned T_ZERO    = DEF_T_ZERO,
  parameter int unsigned T_ONE     = DEF_T_ONE,
  parameter int unsigned T_PILOT   = DEF_T_PILOT,
  parameter int unsigned PILOT_MIN = DEF_PILOT_MIN
) (
  input  logic        clk14,
  input  logic        rst_n,
  input  logic        tape_in,
  input  logic        enable,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        block_start,
  output logic        block_end,
  output logic        checksum_ok,
  output logic [15:0] byte_count,
  output logic        err,
  output logic        busy
);

  localparam int unsigned       PCNT_W   = $clog2(PILOT_MIN + 1);
  localparam logic [PCNT_W-1:0] PCNT_SAT = PCNT_W'(PILOT_MIN);

  logic         pulse_stb;
  pulse_class_e pulse_class;
  logic         timeout_stb;

  tape_pulse_meter #(
    .CNT_W   (CNT_W),
    .T_NOISE (T_NOISE),
    .T_SYNC  (T_SYNC),
    .T_ZERO  (T_ZERO),
    .T_ONE   (T_ONE),
    .T_PILOT (T_PILOT)
  ) u_meter (
    .clk14       (clk14),
    .rst_n       (rst_n),
    .tape_in     (tape_in),
    .pulse_stb   (pulse_stb),
    .pulse_class (pulse_class),
    .timeout_stb (timeout_stb)
  );

  state_e            state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              bit_one_q, bit_one_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [15:0]       byte_count_q, byte_count_d;
  logic [7:0]        data_q, data_d;
  logic              checksum_ok_q, checksum_ok_d;
  logic              data_valid_q, data_valid_d;
  logic              block_start_q, block_start_d;
  logic              block_end_q, block_end_d;
  logic              err_q, err_d;
  logic              abort;
  logic [7:0]        new_shift;

  always_comb begin
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    bit_one_d     = bit_one_q;
    checksum_d    = checksum_q;
    byte_count_d  = byte_count_q;
    data_d        = data_q;
    checksum_ok_d = checksum_ok_q;
    data_valid_d  = 1'b0;
    block_start_d = 1'b0;
    block_end_d   = 1'b0;
    err_d         = 1'b0;
    abort         = 1'b0;
    new_shift     = {shift_q[6:0], bit_one_q};

    if (!enable) begin
      state_d = ST_IDLE;
      pcnt_d  = '0;
    end else if (pulse_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_class == CLS_PILOT) begin
            state_d = ST_PILOT;
            pcnt_d  = PCNT_W'(1);
          end
        end
        ST_PILOT: begin
          if (pulse_class == CLS_PILOT) begin
            if (pcnt_q != PCNT_SAT) pcnt_d = pcnt_q + PCNT_W'(1);
          end else if (pulse_class == CLS_SYNC && pcnt_q >= PCNT_SAT) begin
            state_d = ST_SYNC2;
            pcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
          end
        end
        ST_SYNC2: begin
          if (pulse_class == CLS_SYNC) begin
            state_d       = ST_BIT_H1;
            block_start_d = 1'b1;
            checksum_d    = '0;
            byte_count_d  = '0;
            bit_idx_d     = '0;
            checksum_ok_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BIT_H1: begin
          if (pulse_class == CLS_ZERO || pulse_class == CLS_ONE) begin
            bit_one_d = (pulse_class == CLS_ONE);
            state_d   = ST_BIT_H2;
          end else begin
            abort = 1'b1;
          end
        end
        ST_BIT_H2: begin
          if ((pulse_class == CLS_ONE && bit_one_q) || (pulse_class == CLS_ZERO && !bit_one_q)) begin
            shift_d   = new_shift;
            bit_idx_d = bit_idx_q + 3'd1;
            state_d   = ST_BIT_H1;
            if (bit_idx_q == 3'd7) begin
              data_d       = new_shift;
              data_valid_d = 1'b1;
              checksum_d   = checksum_q ^ new_shift;
              byte_count_d = byte_count_q + 16'd1;
            end
          end else begin
            abort = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_stb) begin
      case (state_q)
        ST_PILOT, ST_SYNC2: begin
          state_d = ST_IDLE;
          pcnt_d  = '0;
        end
        ST_BIT_H1: begin
          // Silence on a byte boundary is the normal end of a block.
          if (bit_idx_q == 3'd0) begin
            state_d       = ST_IDLE;
            block_end_d   = 1'b1;
            checksum_ok_d = (checksum_q == 8'd0) && (byte_count_q != 16'd0);
          end else begin
            abort = 1'b1;
          end
        end
        ST_BIT_H2: abort = 1'b1;
        default: ;
      endcase
    end

    if (abort) begin
      state_d       = ST_IDLE;
      err_d         = 1'b1;
      block_end_d   = 1'b1;
      checksum_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pcnt_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      bit_one_q     <= 1'b0;
      checksum_q    <= '0;
      byte_count_q  <= '0;
      data_q        <= '0;
      checksum_ok_q <= 1'b0;
      data_valid_q  <= 1'b0;
      block_start_q <= 1'b0;
      block_end_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      bit_one_q     <= bit_one_d;
      checksum_q    <= checksum_d;
      byte_count_q  <= byte_count_d;
      data_q        <= data_d;
      checksum_ok_q <= checksum_ok_d;
      data_valid_q  <= data_valid_d;
      block_start_q <= block_start_d;
      block_end_q   <= block_end_d;
      err_q         <= err_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign block_start = block_start_q;
  assign block_end   = block_end_q;
  assign checksum_ok = checksum_ok_q;
  assign byte_count  = byte_count_q;
  assign err         = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tape_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tape_decoder: directed tape streams against a protocol-level      |
// | model of expected block events.  Rev 1.0                             |
// +----------------------------------------------------------------------+
module tb_tape_decoder;

  // Timing scaled down by 80 so whole blocks fit a short run.
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned T_NOISE   = 20;
  localparam int unsigned T_SYNC    = 40;
  localparam int unsigned T_ZERO    = 63;
  localparam int unsigned T_ONE     = 98;
  localparam int unsigned T_PILOT   = 125;
  localparam int unsigned PILOT_MIN = 32;

  localparam int W_PILOT = 108;
  localparam int W_SYNC1 = 33;
  localparam int W_SYNC2 = 37;
  localparam int W_ZERO  = 43;
  localparam int W_ONE   = 86;

  localparam int K_NOISE = 0, K_SYNC = 1, K_ZERO = 2, K_ONE = 3, K_PILOT = 4, K_LONG = 5;
  localparam int EV_START = 0, EV_BYTE = 1, EV_END = 2;

  logic        clk14 = 1'b0;
  logic        rst_n = 1'b0;
  logic        tape_in = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  data;
  logic        data_valid, block_start, block_end, checksum_ok, err, busy;
  logic [15:0] byte_count;

  always #5 clk14 = ~clk14;

  tape_decoder #(
    .CNT_W(CNT_W), .T_NOISE(T_NOISE), .T_SYNC(T_SYNC), .T_ZERO(T_ZERO),
    .T_ONE(T_ONE), .T_PILOT(T_PILOT), .PILOT_MIN(PILOT_MIN)
  ) dut (
    .clk14(clk14), .rst_n(rst_n), .tape_in(tape_in), .enable(enable),
    .data(data), .data_valid(data_valid), .block_start(block_start),
    .block_end(block_end), .checksum_ok(checksum_ok), .byte_count(byte_count),
    .err(err), .busy(busy)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       ok;
    logic       er;
    int         cnt;
  } ev_t;

  ev_t exp_q[$];
  int  widths[$];
  int  checks = 0;
  int  errors = 0;
  int  err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int cls(input int w);
    if (w < int'(T_NOISE)) return K_NOISE;
    if (w < int'(T_SYNC))  return K_SYNC;
    if (w < int'(T_ZERO))  return K_ZERO;
    if (w < int'(T_ONE))   return K_ONE;
    if (w < int'(T_PILOT)) return K_PILOT;
    return K_LONG;
  endfunction

  task automatic push_ev(input int kind, input logic [7:0] d, input logic ok, input logic er, input int cnt);
    ev_t e;
    e.kind = kind; e.data = d; e.ok = ok; e.er = er; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Scans the half-period list for a pilot run plus sync pair, then reads
  // bit pairs. tmo says the stream is followed by enough silence to time out.
  task automatic model(input bit tmo);
    int n, run, j, k, nbits, cnt, c1;
    logic [7:0] b, x;
    n = widths.size(); run = 0; j = 0;
    while (j < n) begin
      if (cls(widths[j]) == K_PILOT) begin
        run++; j++;
      end else if (cls(widths[j]) == K_SYNC && run >= int'(PILOT_MIN)) begin
        if (j + 1 >= n) return;
        if (cls(widths[j+1]) != K_SYNC) begin
          run = 0; j += 2;
        end else begin
          push_ev(EV_START, 8'h00, 1'b0, 1'b0, 0);
          k = j + 2; nbits = 0; cnt = 0; b = 8'h00; x = 8'h00;
          forever begin
            if (k >= n) begin
              if (tmo) push_ev(EV_END, 8'h00, (nbits % 8 == 0) && x == 8'h00 && cnt != 0,
                               nbits % 8 != 0, cnt);
              return;
            end
            c1 = cls(widths[k]);
            if (c1 != K_ZERO && c1 != K_ONE) begin
              push_ev(EV_END, 8'h00, 1'b0, 1'b1, cnt); return;
            end
            if (k + 1 >= n) begin
              if (tmo) push_ev(EV_END, 8'h00, 1'b0, 1'b1, cnt);
              return;
            end
            if (cls(widths[k+1]) != c1) begin
              push_ev(EV_END, 8'h00, 1'b0, 1'b1, cnt); return;
            end
            b = {b[6:0], (c1 == K_ONE)};
            nbits++;
            if (nbits % 8 == 0) begin
              push_ev(EV_BYTE, b, 1'b0, 1'b0, 0);
              x = x ^ b;
              cnt++;
            end
            k += 2;
          end
        end
      end else begin
        run = 0; j++;
      end
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_strobe: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind == EV_BYTE) check("byte_data", data, e.data);
        if (kind == EV_START) check("start_count", byte_count, 0);
        if (kind == EV_END) begin
          check("end_checksum_ok", checksum_ok, e.ok);
          check("end_err", err, e.er);
          check("end_byte_count", byte_count, e.cnt);
        end
      end
    end
  endtask

  always @(negedge clk14) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (err && !block_end) begin
        checks++; errors++;
        $display("FAIL err_without_end: got err=1 block_end=0 expected both");
      end
      if (block_start) observe(EV_START);
      if (data_valid)  observe(EV_BYTE);
      if (block_end)   observe(EV_END);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk14);
  endtask

  task automatic add_pilot(input int n);
    for (int i = 0; i < n; i++) widths.push_back(W_PILOT);
  endtask

  task automatic add_sync();
    widths.push_back(W_SYNC1);
    widths.push_back(W_SYNC2);
  endtask

  task automatic add_bits(input logic [7:0] v, input int nb);
    for (int i = 7; i > 7 - nb; i--) begin
      widths.push_back(v[i] ? W_ONE : W_ZERO);
      widths.push_back(v[i] ? W_ONE : W_ZERO);
    end
  endtask

  task automatic send_stream();
    for (int i = 0; i < widths.size(); i++) begin
      tape_in = ~tape_in;
      idle(widths[i]);
    end
    tape_in = ~tape_in;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk14);
      t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    idle(5);
    @(negedge clk14);
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, data, 0);
    check({name, "_data_valid"}, data_valid, 0);
    check({name, "_block_start"}, block_start, 0);
    check({name, "_block_end"}, block_end, 0);
    check({name, "_checksum_ok"}, checksum_ok, 0);
    check({name, "_byte_count"}, byte_count, 0);
    check({name, "_err"}, err, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    idle(3);
    @(negedge clk14);
    check_all_zero("reset");
    rst_n = 1'b1;
    enable = 1'b1;

    // Good block: FF A5 5A, checksum closes to zero.
    idle(300);
    widths.delete(); add_pilot(36); add_sync();
    add_bits(8'hFF, 8); add_bits(8'hA5, 8); add_bits(8'h5A, 8);
    model(1);
    check("t1_model_events", exp_q.size(), 5);
    send_stream();
    drain("t1");
    check("t1_data", data, 8'h5A);
    check("t1_byte_count", byte_count, 3);
    check("t1_checksum_ok", checksum_ok, 1);

    // Bad checksum: last byte 5B, no err.
    idle(300);
    e0 = err_seen;
    widths.delete(); add_pilot(36); add_sync();
    add_bits(8'hFF, 8); add_bits(8'hA5, 8); add_bits(8'h5B, 8);
    model(1);
    send_stream();
    drain("t2");
    check("t2_checksum_ok", checksum_ok, 0);
    check("t2_byte_count", byte_count, 3);
    check("t2_no_err", err_seen - e0, 0);

    // Short pilot: sync must be refused.
    idle(300);
    widths.delete(); add_pilot(12); add_sync();
    model(1);
    check("t3_model_events", exp_q.size(), 0);
    send_stream();
    idle(300);
    drain("t3");

    // Half-period mismatch: ZERO then ONE.
    idle(300);
    e0 = err_seen;
    widths.delete(); add_pilot(36); add_sync();
    widths.push_back(W_ZERO); widths.push_back(W_ONE);
    model(1);
    check("t4_model_events", exp_q.size(), 2);
    send_stream();
    drain("t4");
    check("t4_err_count", err_seen - e0, 1);
    check("t4_checksum_ok", checksum_ok, 0);

    // Silence after three bits.
    idle(300);
    widths.delete(); add_pilot(36); add_sync(); add_bits(8'hA0, 3);
    model(1);
    send_stream();
    drain("t5");
    check("t5_checksum_ok", checksum_ok, 0);

    // Reset mid-byte.
    idle(300);
    widths.delete(); add_pilot(36); add_sync(); add_bits(8'hC0, 3);
    model(0);
    check("t6_model_events", exp_q.size(), 1);
    send_stream();
    idle(20);
    check("t6_start_seen", exp_q.size(), 0);
    @(negedge clk14);
    check("t6_busy_mid_byte", busy, 1);
    @(posedge clk14);
    #3 rst_n = 1'b0;
    #1 check_all_zero("t6_reset");
    @(negedge clk14);
    rst_n = 1'b1;

    // Enable dropped mid-pilot.
    idle(300);
    widths.delete(); add_pilot(20);
    model(1);
    send_stream();
    idle(10);
    @(negedge clk14);
    check("t7_busy_pilot", busy, 1);
    enable = 1'b0;
    @(posedge clk14);
    @(negedge clk14);
    check("t7_busy_disabled", busy, 0);
    widths.delete(); add_pilot(10);
    send_stream();
    idle(300);
    @(negedge clk14);
    check("t7_busy_still_idle", busy, 0);
    enable = 1'b1;
    idle(300);
    drain("t7");
    check("t7_byte_count_held", byte_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
